// File: rtl/iffifo_arb_pkg.sv
// iffifo slot arbiter shared types.
// FSM state and index-width helper.
package iffifo_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } iffifo_arb_state_e;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/iffifo_rr_pick.sv
// Combinational round-robin select.
// Rotate past last, priority encode, un-rotate.
module iffifo_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IdxW    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_i,
  output logic               valid_o,
  output logic [IdxW-1:0]    idx_o
);

  logic [IdxW:0]        w_sh;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IdxW-1:0]      w_off;
  logic [IdxW:0]        w_sum;

  assign w_sh  = {1'b0, last_i} + (IdxW+1)'(1);
  assign w_dbl = {req_i, req_i};
  assign w_rot = NUM_REQ'(w_dbl >> w_sh);

  // lowest set bit of the rotated vector wins
  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IdxW'(k);
    end
  end

  assign valid_o = |req_i;
  assign w_sum   = {1'b0, w_off} + w_sh;
  assign idx_o   = (w_sum >= (IdxW+1)'(NUM_REQ))
                 ? IdxW'(w_sum - (IdxW+1)'(NUM_REQ))
                 : IdxW'(w_sum);

endmodule

// File: rtl/iffifo_slot_arbiter.sv
// Round-robin owner of the iffifo write slot.
// Grants last a burst of pushes or until req drops.
module iffifo_slot_arbiter
  import iffifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BURST_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic               fifo_ready_i,
  input  logic               push_i,
  input  logic               clr_err_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [NUM_REQ-1:0] slot_ready_o,
  output logic               busy_o,
  output logic               burst_done_o,
  output logic               push_err_o
);

  localparam int IdxW = idx_w(NUM_REQ);

  iffifo_arb_state_e  r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [BURST_W-1:0] r_cnt;
  logic [IdxW-1:0]    r_last;
  logic               r_done;
  logic               r_err;

  logic               w_pick_vld;
  logic [IdxW-1:0]    w_pick_idx;
  logic               w_req_g;
  logic               w_exh;

  iffifo_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IdxW   (IdxW)
  ) u_pick (
    .req_i  (req_i),
    .last_i (r_last),
    .valid_o(w_pick_vld),
    .idx_o  (w_pick_idx)
  );

  // cnt of zero while granted means unlimited
  assign w_req_g = |(req_i & r_grant);
  assign w_exh   = (r_state == GRANTED) && push_i
                && (r_cnt == BURST_W'(1));

  // grant FSM, burst counter and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_cnt   <= '0;
      r_last  <= IdxW'(NUM_REQ - 1);
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_state <= GRANTED;
            r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1}
                       << w_pick_idx;
            r_last  <= w_pick_idx;
            r_cnt   <= burst_len_i;
          end
        end
        GRANTED: begin
          if (push_i && (r_cnt != '0))
            r_cnt <= r_cnt - BURST_W'(1);
          if (w_exh) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
            r_grant <= '0;
          end else if (!w_req_g) begin
            r_state <= IDLE;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  // sticky push-while-idle flag, set beats clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (push_i && (r_state == IDLE)) begin
      r_err <= 1'b1;
    end else if (clr_err_i) begin
      r_err <= 1'b0;
    end
  end

  assign grant_o      = r_grant;
  assign slot_ready_o = r_grant & {NUM_REQ{fifo_ready_i}};
  assign busy_o       = (r_state == GRANTED);
  assign burst_done_o = r_done;
  assign push_err_o   = r_err;

endmodule

// File: tb/tb_iffifo_slot_arbiter.sv
// Bench for iffifo_slot_arbiter.
// Directed plus random traffic vs a rule model.
module tb_iffifo_slot_arbiter;

  localparam int N  = 4;
  localparam int BW = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [N-1:0]  req_i = '0;
  logic [BW-1:0] burst_len_i = '0;
  logic          fifo_ready_i = 1'b0;
  logic          push_i = 1'b0;
  logic          clr_err_i = 1'b0;
  logic [N-1:0]  grant_o;
  logic [N-1:0]  slot_ready_o;
  logic          busy_o;
  logic          burst_done_o;
  logic          push_err_o;

  int n_chk = 0;
  int n_err = 0;

  // model: who owns the slot, words left, fairness pointer
  int m_owner;
  int m_left;
  int m_last;
  bit m_done;
  bit m_err;

  always #5 clk_i = ~clk_i;

  iffifo_slot_arbiter #(
    .NUM_REQ(N),
    .BURST_W(BW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .burst_len_i (burst_len_i),
    .fifo_ready_i(fifo_ready_i),
    .push_i      (push_i),
    .clr_err_i   (clr_err_i),
    .grant_o     (grant_o),
    .slot_ready_o(slot_ready_o),
    .busy_o      (busy_o),
    .burst_done_o(burst_done_o),
    .push_err_o  (push_err_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_left  = 0;
    m_last  = N - 1;
    m_done  = 0;
    m_err   = 0;
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("grant", 32'(grant_o), 32'(eg));
    chk("slot", 32'(slot_ready_o),
        32'(fifo_ready_i ? eg : '0));
    chk("busy", 32'(busy_o), 32'(m_owner >= 0));
    chk("done", 32'(burst_done_o), 32'(m_done));
    chk("perr", 32'(push_err_o), 32'(m_err));
  endtask

  // one clock of the arbitration rules
  task automatic model_clock();
    m_done = 0;
    if (m_owner < 0) begin
      if (push_i) m_err = 1;
      else if (clr_err_i) m_err = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (req_i[c]) begin
          m_owner = c;
          m_last  = c;
          m_left  = int'(burst_len_i);
          break;
        end
      end
    end else begin
      if (clr_err_i) m_err = 0;
      if (push_i && m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done  = 1;
          m_owner = -1;
        end
      end
      if (m_owner >= 0 && !req_i[m_owner])
        m_owner = -1;
    end
  endtask

  task automatic step(input logic [N-1:0] rq,
                      input logic [BW-1:0] bl,
                      input logic fr,
                      input logic ps,
                      input logic cl);
    @(negedge clk_i);
    req_i        = rq;
    burst_len_i  = bl;
    fifo_ready_i = fr;
    push_i       = ps;
    clr_err_i    = cl;
    #1;
    check_all();
    model_clock();
  endtask

  initial begin
    model_reset();
    #12 rst_ni = 1'b1;
    #1 check_all();

    // single burst of three on ch0
    step(4'b0001, 8'd3, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step(4'b0001, 8'd3, 1, 1, 0);
    step(4'b0000, 8'd3, 1, 0, 0);
    step(4'b0000, 8'd3, 1, 0, 0);

    // all request, one word per grant
    for (int i = 0; i < 12; i++)
      step(4'b1111, 8'd1, 1, busy_o, 0);
    step(4'b0000, 8'd1, 1, 0, 0);
    step(4'b0000, 8'd1, 1, 0, 0);

    // ch2 aborts after two of four
    step(4'b0100, 8'd4, 1, 0, 0);
    step(4'b0100, 8'd4, 1, 1, 0);
    step(4'b0100, 8'd4, 1, 1, 0);
    step(4'b0000, 8'd4, 1, 0, 0);
    step(4'b1001, 8'd4, 1, 0, 0);
    step(4'b1001, 8'd4, 1, 0, 0);
    step(4'b0000, 8'd4, 1, 0, 0);

    // ch1 with FIFO full/empty toggling
    step(4'b0010, 8'd5, 1, 0, 0);
    step(4'b0010, 8'd5, 1, 0, 0);
    step(4'b0010, 8'd5, 0, 0, 0);
    step(4'b0010, 8'd5, 0, 0, 0);
    step(4'b0010, 8'd5, 1, 0, 0);
    step(4'b0000, 8'd5, 1, 0, 0);

    // error flag set/clear/priority
    step(4'b0000, 8'd0, 1, 1, 0);
    step(4'b0000, 8'd0, 1, 0, 0);
    step(4'b0000, 8'd0, 1, 0, 1);
    step(4'b0000, 8'd0, 1, 1, 0);
    step(4'b0000, 8'd0, 1, 1, 1);
    step(4'b0000, 8'd0, 1, 0, 0);
    step(4'b0000, 8'd0, 1, 0, 1);

    // unlimited burst, 300 words
    step(4'b0001, 8'd0, 1, 0, 0);
    for (int i = 0; i < 300; i++)
      step(4'b0001, BW'($urandom), 1, 1, 0);

    // asynchronous reset mid-burst
    #2 rst_ni = 1'b0;
    req_i  = '0;
    push_i = 1'b0;
    clr_err_i = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(4'b1111, 8'd2, 1, 0, 0);
    step(4'b1111, 8'd2, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] rq;
      rq = N'($urandom);
      if ($urandom_range(3) == 0) rq = '0;
      step(rq,
           BW'($urandom_range(4)),
           1'($urandom),
           1'($urandom_range(2) != 0),
           1'($urandom_range(7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
